// File: rtl/mac_seq_pkg.sv
// Shared types and constant helpers for the sequential multiply-accumulate unit.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        ACC  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Widest accumulator the saturation helpers can describe.
    localparam int SAT_MAX_W = 512;

    function automatic int acc_width(input int width, input int guard);
        return 2 * width + guard;
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_smax(input int w);
        logic [SAT_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < w - 1; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_smin(input int w);
        logic [SAT_MAX_W-1:0] v;
        v = '0;
        v[w-1] = 1'b1;
        return v;
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_umax(input int w);
        logic [SAT_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < w; i++) v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mac_seq_param_mult.sv
// Iterative radix-2 unsigned shift-add multiplier: one partial product per cycle,
// always WIDTH cycles after start, with done high during the final iteration.
module shift_add_mult_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               running;

    assign done = running && (count == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            count   <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
        end else if (running) begin
            count <= count + 1'b1;
            if (done) running <= 1'b0;
        end
    end

    // No early exit on zero operands: the loop length is fixed by WIDTH.
    always_ff @(posedge clk) begin
        if (start) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            product <= '0;
        end else if (running) begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mac_seq_param.sv
// Sequential signed/unsigned multiply-accumulate with valid/ready framing.
// Define MAC_SEQ_SAT_EN to saturate the accumulator and report out_ovf.
import mac_seq_pkg::*;

module mac_seq_param #(
    parameter int WIDTH = 32,
    parameter int GUARD = 8,
    parameter int ACC_W = acc_width(WIDTH, GUARD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    input  logic             in_clr,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    localparam int PW  = 2 * WIDTH;
    localparam int EXT = ACC_W - PW;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             sgn_q;
    logic             neg_q;
    logic             clr_q;
    logic             last_q;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]    prod_mag;
    logic [PW-1:0]    prod;
    logic             mult_done;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;

    assign accept    = (state == IDLE) && in_valid;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign out_acc   = acc;

    // Signed operands enter the unsigned core as magnitudes; the most negative
    // value negates to itself, which read unsigned is exactly its magnitude.
    assign mag_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    assign mag_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;

    shift_add_mult_iter #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .a       (mag_a),
        .b       (mag_b),
        .product (prod_mag),
        .done    (mult_done)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            sgn_q  <= in_signed;
            neg_q  <= in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            clr_q  <= in_clr;
            last_q <= in_last;
        end
    end

    assign prod     = neg_q ? -prod_mag : prod_mag;
    assign prod_ext = {{EXT{sgn_q & prod[PW-1]}}, prod};
    assign base     = clr_q ? '0 : acc;

`ifdef MAC_SEQ_SAT_EN
    localparam logic [ACC_W-1:0] SMAX = ACC_W'(sat_smax(ACC_W));
    localparam logic [ACC_W-1:0] SMIN = ACC_W'(sat_smin(ACC_W));
    localparam logic [ACC_W-1:0] UMAX = ACC_W'(sat_umax(ACC_W));

    logic ovf_hit;
    logic ovf_q;

    // Returns {clamped, sum}; signed pairs clamp two-sided, unsigned pairs only high.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] x,
                                               input logic [ACC_W-1:0] y,
                                               input logic             s);
        logic [ACC_W:0] raw;
        raw = {1'b0, x} + {1'b0, y};
        if (s) begin
            if ((x[ACC_W-1] == y[ACC_W-1]) && (raw[ACC_W-1] != x[ACC_W-1]))
                return {1'b1, (x[ACC_W-1] ? SMIN : SMAX)};
        end else if (raw[ACC_W]) begin
            return {1'b1, UMAX};
        end
        return {1'b0, raw[ACC_W-1:0]};
    endfunction

    always_comb begin
        {ovf_hit, acc_nxt} = sat_add(base, prod_ext, sgn_q);
    end

    always_ff @(posedge clk) begin
        if (rst)                           ovf_q <= 1'b0;
        else if (state == ACC && ovf_hit)  ovf_q <= 1'b1;
        else if (state == OUT && out_ready) ovf_q <= 1'b0;
    end

    assign out_ovf = ovf_q;
`else
    assign acc_nxt = base + prod_ext;
    assign out_ovf = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = MULT;
            MULT:    if (mult_done) state_nxt = ACC;
            ACC:     state_nxt = last_q ? OUT : IDLE;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ACC)                    acc <= acc_nxt;
            else if (state == OUT && out_ready)  acc <= '0;
        end
    end

endmodule

// File: tb/tb_mac_seq_param.sv
// Directed bench for mac_seq_param (WIDTH=8, GUARD=4) with an arithmetic reference model.
module tb_mac_seq_param;

    localparam int W     = 8;
    localparam int AW    = 20;
    localparam longint MASK = (64'd1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_signed;
    logic          in_clr;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_acc;
    logic          out_ovf;
    logic          busy;

    mac_seq_param #(.WIDTH(W), .GUARD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_clr    (in_clr),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint acc;
        bit     ovf;
        int     due;
    } exp_t;

    exp_t   q[$];
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     mult_end = 0;
    bit     started = 0;
    bit     ov_exp;
    bit     ir_exp;
    longint m_acc = 0;
    bit     m_ovf = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: the accumulator as an AW-bit pattern, updated by plain integer arithmetic.
    task automatic model_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                              input bit s, input bit c, input bit l);
        longint p;
        longint base;
        longint sum;
        p = s ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
        if (c) base = 0;
        else if (s && m_acc >= (64'd1 << (AW - 1))) base = m_acc - (64'd1 << AW);
        else base = m_acc;
        sum = base + p;
`ifdef MAC_SEQ_SAT_EN
        if (s && sum > (64'd1 << (AW - 1)) - 1) begin
            sum = (64'd1 << (AW - 1)) - 1; m_ovf = 1;
        end else if (s && sum < -(longint'(1) << (AW - 1))) begin
            sum = -(longint'(1) << (AW - 1)); m_ovf = 1;
        end else if (!s && sum > MASK) begin
            sum = MASK; m_ovf = 1;
        end
`endif
        m_acc = sum & MASK;
        if (l) begin
            q.push_back('{acc: m_acc, ovf: m_ovf, due: mult_end});
            m_acc = 0;
            m_ovf = 0;
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit s, input bit c, input bit l);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk("send_wait_ready", 0, 1);
        in_valid = 1; in_a = a; in_b = b; in_signed = s; in_clr = c; in_last = l;
        @(posedge clk); #1;
        in_valid = 0;
        mult_end = cyc + W + 1;
        model_pair(a, b, s, c, l);
    endtask

    task automatic wait_result(input string name, input longint lit_acc, input bit lit_ovf);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!out_valid && guard < 60);
        chk({name, "_seen"}, out_valid, 1);
        chk({name, "_acc"}, out_acc, lit_acc);
        chk({name, "_ovf"}, out_ovf, lit_ovf);
        @(posedge clk); #1;
    endtask

    // Cycle-by-cycle comparison of the handshake outputs and result against the model.
    always @(negedge clk) begin
        if (started && !rst) begin
            ov_exp = (q.size() != 0) && (cyc >= q[0].due);
            ir_exp = (cyc >= mult_end) && (q.size() == 0);
            chk("in_ready", in_ready, ir_exp);
            chk("busy", busy, !ir_exp);
            chk("out_valid", out_valid, ov_exp);
            if (ov_exp) begin
                chk("out_acc", out_acc, q[0].acc);
                chk("out_ovf", out_ovf, q[0].ovf);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; in_valid = 0; in_a = '0; in_b = '0;
        in_signed = 0; in_clr = 0; in_last = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_acc", out_acc, 0);
        chk("rst_out_ovf", out_ovf, 0);
        started = 1;

        // Unsigned single product, clr and last together.
        send(8'd200, 8'd200, 0, 1, 1);
        wait_result("unsigned_single", 40000, 0);

        // Signed group of three including most-negative squared.
        send(8'hFD, 8'd5, 1, 1, 0);
        send(8'd7, 8'hFE, 1, 0, 0);
        send(8'h80, 8'h80, 1, 0, 1);
        wait_result("signed_group", 16355, 0);

        // Negative single result is sign-extended to the full accumulator.
        send(8'hF9, 8'd9, 1, 1, 1);
        wait_result("signed_neg", 20'hFFFC1, 0);

        // Backpressure: result held for 20 cycles, then one-cycle handshake.
        out_ready = 0;
        send(8'd3, 8'd7, 0, 1, 1);
        wait_result("backpressure", 21, 0);
        repeat (19) begin @(posedge clk); #1; end
        chk("bp_held_acc", out_acc, 21);
        chk("bp_held_valid", out_valid, 1);
        out_ready = 1;
        @(posedge clk); #1;
        chk("bp_after_valid", out_valid, 0);
        chk("bp_after_ready", in_ready, 1);
        chk("bp_after_acc", out_acc, 0);

        // Reset in the middle of a multiply discards the pair and the open group.
        send(8'd9, 8'd9, 0, 1, 0);
        send(8'd5, 8'd6, 0, 0, 1);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        q.delete(); mult_end = 0; m_acc = 0; m_ovf = 0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_acc", out_acc, 0);
        send(8'd3, 8'd4, 0, 0, 1);
        wait_result("after_reset", 12, 0);

        // Accumulator overflow across 17 pairs of 255*255.
        for (int i = 0; i < 17; i++) send(8'd255, 8'd255, 0, i == 0, i == 16);
`ifdef MAC_SEQ_SAT_EN
        wait_result("overflow", 20'hFFFFF, 1);
`else
        wait_result("overflow", 56849, 0);
`endif

        // Zero operand runs the full loop; valid held while busy is not captured.
        send(8'd3, 8'd4, 0, 1, 0);
        send(8'd0, 8'd255, 0, 0, 0);
        in_valid = 1; in_a = 8'd99; in_b = 8'd99; in_clr = 1; in_last = 1;
        repeat (5) begin @(posedge clk); #1; end
        in_valid = 0;
        chk("zero_busy_mid", busy, 1);
        send(8'd1, 8'd1, 0, 0, 1);
        wait_result("zero_operand", 13, 0);

        repeat (3) begin @(posedge clk); #1; end
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_seq_param.md
Name: mac_seq_param

Overview:
- Parametrised iterative multiply-accumulate unit; next generation of the 256-bit shift-add MAC.
- Width is generic, and each operand pair is signed or unsigned.
- Explicit valid/ready handshakes replace the free-running counter; accumulator clear and end-of-group are framed per operand pair.
- Sits between an operand streamer and a result sink in the MAC datapath; one radix-2 partial product per cycle.

Parameters:
- WIDTH, 32, operand width in bits (>=2).
- GUARD, 8, accumulator guard bits above the 2*WIDTH product.
- ACC_W, 2*WIDTH+GUARD, accumulator/result width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  unit can accept a pair.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- in_clr  in  1  zero the accumulator before adding this product.
- in_last  in  1  this product closes the group; emit the result.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts the result.
- out_acc  out  ACC_W  accumulated result.
- out_ovf  out  1  sticky overflow for the group (see Optional Feature).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at a clk edge) applies regardless of state, including mid-multiply:
  - state=IDLE, acc=0, bit counter=0, out_valid=0, out_ovf=0, in_ready=1, busy=0.
  - The in-flight product is discarded.
- FSM states: IDLE, MULT, ACC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture a, b, signed, clr and last.
  - If signed=1, capture operand magnitudes plus the product sign (sign_a XOR sign_b).
  - Next state MULT.
- MULT:
  - Runs exactly WIDTH cycles.
  - Each cycle, if the multiplier LSB is 1, add the shifted multiplicand into a 2*WIDTH product register; then shift.
  - After the last bit, next state ACC.
- ACC:
  - If the sign flag is set, negate the product.
  - Sign-extend (signed) or zero-extend (unsigned) the product to ACC_W.
  - acc <= (clr ? 0 : acc) + product.
  - Next state OUT if last=1, else IDLE.
- OUT:
  - out_valid=1 and out_acc=acc, both held stable until out_ready=1.
  - On the handshake: acc <= 0, out_ovf <= 0, next state IDLE.
  - out_ready is ignored outside OUT.
- Latency: with a pair accepted at edge t:
  - MULT occupies t+1..t+WIDTH.
  - acc updates at t+WIDTH+1.
  - in_ready or out_valid is high from t+WIDTH+2.
  - Throughput is one pair per WIDTH+2 cycles when last=0.
- Boundary conditions:
  - in_a or in_b = 0: the full WIDTH cycles still run; no early exit.
  - Signed most-negative x most-negative (e.g. -128*-128 at WIDTH=8): the product fits in 2*WIDTH bits with no special case.
  - in_valid held while not ready: no capture; inputs are don't-care.
  - in_clr=1 together with in_last=1: out_acc is that single product.
  - Accumulator overflow without the macro: wraps modulo 2^ACC_W, out_ovf stays 0.
- out_acc always reflects acc; it is only meaningful when out_valid=1.

Optional Feature:
- Macro: MAC_SEQ_SAT_EN.
- Defined:
  - The ACC-state add saturates instead of wrapping.
  - Signed pairs clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Unsigned pairs clamp to 2^ACC_W-1.
  - out_ovf is set on any clamp and stays set until the OUT handshake or reset.
- Not defined:
  - Wrap-around arithmetic; out_ovf is tied 0.
  - No saturation logic is synthesised.

Decomposition:
- Package mac_seq_pkg:
  - state enum (IDLE, MULT, ACC, OUT).
  - acc_width function (2*WIDTH+GUARD).
  - Saturation min/max constant functions.
- One sub-module, shift_add_mult_iter:
  - Iterative radix-2 unsigned multiplier.
  - Ports: start, a, b, product, done.
  - Instantiated once in MULT.
- Sign handling, accumulator and FSM live in the top.

Test Plan (WIDTH=8, GUARD=4, ACC_W=20):
- Unsigned single: a=200, b=200, signed=0, clr=1, last=1 -> out_valid at accept+10 with out_acc=40000 (0x09C40), out_ovf=0.
- Signed group of three: (-3*5), (7*-2), (-128*-128), clr on the first and last on the third -> out_acc=-15-14+16384=16355 (0x03FE3).
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_acc stable, in_ready=0; release -> one-cycle handshake, then in_ready=1 and acc=0.
- Reset mid-multiply: assert rst at accept+4 -> next cycle state IDLE, in_ready=1, out_valid=0; a following pair 3*4 with last=1 -> out_acc=12.
- Overflow: 17 unsigned pairs of 255*255 (65025 each; total 1105425 > 2^20-1) with last on the 17th -> without MAC_SEQ_SAT_EN out_acc=56849 (0x0DE11), out_ovf=0; with it out_acc=0xFFFFF, out_ovf=1.
- Zero operand: a=0, b=255 -> ACC still reached at accept+9 and acc unchanged.
